// File: rtl/mbist_march_controller.sv
// rtl/mbist_march_controller.sv - March C- MBIST controller for a 1W/2R register file
// Optional MBIST_DIAG_EN adds fail_data, fail_port and error_count diagnostics.
module mbist_march_controller #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] mem_data_out0,
  input  logic [DATA_WIDTH-1:0] mem_data_out1,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr0,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr1,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en0,
  output logic                  mem_rd_en1,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_element
`ifdef MBIST_DIAG_EN
  ,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic                  fail_port,
  output logic [7:0]            error_count
`endif
);

  typedef enum logic [2:0] {IDLE, WR, RD, RW, DUALRD, DRAIN, DONE} state_t;

  localparam logic [DATA_WIDTH-1:0] B0 = '0;
  localparam logic [DATA_WIDTH-1:0] B1 = '1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  state_t                  state, nstate;
  logic [ADDR_WIDTH-1:0]   addr, naddr, step;
  logic [2:0]              elem, nelem;
  logic                    ascending, at_end, accept;
  logic [DATA_WIDTH-1:0]   nwdata, nexp;
  logic [1:0]              nmask;
  logic [1:0]              p0_mask, p1_mask;
  logic [DATA_WIDTH-1:0]   p0_exp, p1_exp;
  logic [ADDR_WIDTH-1:0]   p0_addr, p1_addr;
  logic [2:0]              p0_elem, p1_elem;
  logic                    mis0, mis1;

  always_comb begin
    nstate    = state;
    naddr     = addr;
    nelem     = elem;
    accept    = (state == IDLE || state == DONE) && start;
    ascending = !(elem == 3'd3 || elem == 3'd4);
    at_end    = ascending ? (addr == LAST_ADDR) : (addr == '0);
    step      = ascending ? addr + ADDR_WIDTH'(1) : addr - ADDR_WIDTH'(1);
    case (state)
      IDLE, DONE: if (start) begin
        nstate = WR;
        naddr  = '0;
        nelem  = 3'd0;
      end
      WR: if (at_end) begin
        nstate = RD;
        nelem  = 3'd1;
        naddr  = '0;
      end else begin
        naddr = step;
      end
      RD: nstate = RW;
      RW: if (at_end) begin
        if (elem == 3'd4) begin
          nstate = DUALRD;
          nelem  = 3'd5;
          naddr  = '0;
        end else begin
          // The next element starts at the top when it descends (M3, M4).
          nstate = RD;
          nelem  = elem + 3'd1;
          naddr  = (elem == 3'd2 || elem == 3'd3) ? LAST_ADDR : '0;
        end
      end else begin
        nstate = RD;
        naddr  = step;
      end
      DUALRD: if (at_end) nstate = DRAIN;
              else        naddr  = step;
      DRAIN: nstate = DONE;
      default: nstate = IDLE;
    endcase
    nwdata = (nstate == RW && (nelem == 3'd1 || nelem == 3'd3)) ? B1 : B0;
    nexp   = (nelem == 3'd2 || nelem == 3'd4) ? B1 : B0;
    nmask  = {nstate == DUALRD, nstate == RD || nstate == DUALRD};
    mis0   = p1_mask[0] && (mem_data_out0 != p1_exp);
    mis1   = p1_mask[1] && (mem_data_out1 != p1_exp);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      addr         <= '0;
      elem         <= '0;
      mem_data_in  <= '0;
      mem_wr_addr  <= '0;
      mem_rd_addr0 <= '0;
      mem_rd_addr1 <= '0;
      mem_wr_en    <= 1'b0;
      mem_rd_en0   <= 1'b0;
      mem_rd_en1   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fail         <= 1'b0;
      fail_addr    <= '0;
      fail_element <= '0;
      p0_mask      <= '0;
      p1_mask      <= '0;
      p0_exp       <= '0;
      p1_exp       <= '0;
      p0_addr      <= '0;
      p1_addr      <= '0;
      p0_elem      <= '0;
      p1_elem      <= '0;
`ifdef MBIST_DIAG_EN
      fail_data    <= '0;
      fail_port    <= 1'b0;
      error_count  <= '0;
`endif
    end else begin
      state        <= nstate;
      addr         <= naddr;
      elem         <= nelem;
      mem_data_in  <= nwdata;
      mem_wr_addr  <= naddr;
      mem_rd_addr0 <= naddr;
      mem_rd_addr1 <= naddr;
      mem_wr_en    <= (nstate == WR || nstate == RW);
      mem_rd_en0   <= nmask[0];
      mem_rd_en1   <= nmask[1];
      busy         <= (nstate != IDLE && nstate != DONE);
      done         <= (nstate == DONE);
      // Stage 0 tracks the read being driven; stage 1 lines up with returned data.
      p0_mask      <= nmask;
      p0_exp       <= nexp;
      p0_addr      <= naddr;
      p0_elem      <= nelem;
      p1_mask      <= p0_mask;
      p1_exp       <= p0_exp;
      p1_addr      <= p0_addr;
      p1_elem      <= p0_elem;
      if (accept) begin
        fail         <= 1'b0;
        fail_addr    <= '0;
        fail_element <= '0;
`ifdef MBIST_DIAG_EN
        fail_data    <= '0;
        fail_port    <= 1'b0;
        error_count  <= '0;
`endif
      end else if (mis0 || mis1) begin
        fail <= 1'b1;
        if (!fail) begin
          fail_addr    <= p1_addr;
          fail_element <= p1_elem;
`ifdef MBIST_DIAG_EN
          fail_data    <= mis0 ? mem_data_out0 : mem_data_out1;
          fail_port    <= !mis0;
`endif
        end
`ifdef MBIST_DIAG_EN
        if (error_count != 8'hFF) error_count <= error_count + 8'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mbist_march_controller.sv
// tb/tb_mbist_march_controller.sv - directed bench for mbist_march_controller with a faultable memory model
module tb_mbist_march_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dout0 = 8'h00;
  logic [7:0] dout1 = 8'h00;
  logic [7:0] mem_data_in;
  logic [3:0] mem_wr_addr, mem_rd_addr0, mem_rd_addr1;
  logic       mem_wr_en, mem_rd_en0, mem_rd_en1;
  logic       busy, done, fail;
  logic [3:0] fail_addr;
  logic [2:0] fail_element;
`ifdef MBIST_DIAG_EN
  logic [7:0] fail_data;
  logic       fail_port;
  logic [7:0] error_count;
`endif

  int checks = 0;
  int errors = 0;
  int fault_mode = 0;
  int rd0_cnt = 0;
  int rd1_cnt = 0;
  logic [7:0] mem [16];
  logic [7:0] wlog_data [$];
  logic [3:0] wlog_addr [$];

  always #5 clock = ~clock;

  mbist_march_controller #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_WORDS(16)) dut (
    .clock(clock), .reset(reset), .start(start),
    .mem_data_out0(dout0), .mem_data_out1(dout1),
    .mem_data_in(mem_data_in), .mem_wr_addr(mem_wr_addr),
    .mem_rd_addr0(mem_rd_addr0), .mem_rd_addr1(mem_rd_addr1),
    .mem_wr_en(mem_wr_en), .mem_rd_en0(mem_rd_en0), .mem_rd_en1(mem_rd_en1),
    .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_element(fail_element)
`ifdef MBIST_DIAG_EN
    , .fail_data(fail_data), .fail_port(fail_port), .error_count(error_count)
`endif
  );

  // Mode 1: addr 5 bit 3 stuck at 1. Mode 2: a 1->0 write of bit 0 at addr 9 flips addr 8 bit 0.
  // Mode 3: read port 1 bit 0 stuck high at addr 15.
  always @(posedge clock) begin
    if (mem_rd_en0) begin
      dout0 <= mem[mem_rd_addr0] | ((fault_mode == 1 && mem_rd_addr0 == 4'd5) ? 8'h08 : 8'h00);
      rd0_cnt = rd0_cnt + 1;
    end
    if (mem_rd_en1) begin
      dout1 <= mem[mem_rd_addr1] | ((fault_mode == 1 && mem_rd_addr1 == 4'd5) ? 8'h08 : 8'h00)
                                 | ((fault_mode == 3 && mem_rd_addr1 == 4'd15) ? 8'h01 : 8'h00);
      rd1_cnt = rd1_cnt + 1;
    end
    if (mem_wr_en) begin
      mem[mem_wr_addr] <= mem_data_in;
      if (fault_mode == 2 && mem_wr_addr == 4'd9 && mem[9][0] == 1'b1 && mem_data_in[0] == 1'b0)
        mem[8] <= mem[8] ^ 8'h01;
      wlog_data.push_back(mem_data_in);
      wlog_addr.push_back(mem_wr_addr);
    end
  end

  function automatic int seq_errors(input int base);
    int n = 0;
    int e, a;
    logic [3:0] ea;
    logic [7:0] ed;
    if (wlog_data.size() - base != 80) return 1000;
    for (int i = 0; i < 80; i++) begin
      e  = i / 16;
      a  = i % 16;
      ea = (e == 3 || e == 4) ? 4'(15 - a) : 4'(a);
      ed = (e == 1 || e == 3) ? 8'hFF : 8'h00;
      if (wlog_data[base + i] !== ed || wlog_addr[base + i] !== ea) n++;
    end
    return n;
  endfunction

  task automatic kick();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int pa, input int pb, output int cycles, output int gaps);
    cycles = -1;
    gaps   = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clock);
      start = (k == pa || k == pb);
      @(posedge clock);
      #1 start = 1'b0;
      if (done) begin
        cycles = k;
        break;
      end
      if (!busy) gaps++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b expected 0", done); end
    checks++; if (fail !== 1'b0 || fail_addr !== 4'd0 || fail_element !== 3'd0) begin
      errors++; $display("FAIL reset_fail got %0b/%0d/%0d expected 0/0/0", fail, fail_addr, fail_element); end
    checks++; if ({mem_wr_en, mem_rd_en0, mem_rd_en1} !== 3'b000) begin
      errors++; $display("FAIL reset_enables got %b expected 000", {mem_wr_en, mem_rd_en0, mem_rd_en1}); end
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_fault_free();
    int base, r0, r1, cyc, gaps;
    fault_mode = 0;
    base = wlog_data.size();
    r0 = rd0_cnt;
    r1 = rd1_cnt;
    kick();
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL ff_busy_edge0 got busy=%0b done=%0b expected 1/0", busy, done); end
    checks++; if (mem_wr_en !== 1'b1 || mem_wr_addr !== 4'd0 || mem_data_in !== 8'h00) begin
      errors++; $display("FAIL ff_first_write got en=%0b a=%0d d=%h expected 1/0/00", mem_wr_en, mem_wr_addr, mem_data_in); end
    wait_done(0, 0, cyc, gaps);
    checks++; if (cyc !== 161) begin errors++; $display("FAIL ff_done_cycle got %0d expected 161", cyc); end
    checks++; if (gaps !== 0) begin errors++; $display("FAIL ff_busy_gaps got %0d expected 0", gaps); end
    checks++; if (busy !== 1'b0 || fail !== 1'b0) begin
      errors++; $display("FAIL ff_end got busy=%0b fail=%0b expected 0/0", busy, fail); end
    checks++; if (seq_errors(base) !== 0) begin
      errors++; $display("FAIL ff_write_seq got %0d bad writes expected 0", seq_errors(base)); end
    checks++; if (rd0_cnt - r0 !== 80 || rd1_cnt - r1 !== 16) begin
      errors++; $display("FAIL ff_read_counts got %0d/%0d expected 80/16", rd0_cnt - r0, rd1_cnt - r1); end
    repeat (3) @(posedge clock);
    #1;
    checks++; if (done !== 1'b1 || {mem_wr_en, mem_rd_en0, mem_rd_en1} !== 3'b000) begin
      errors++; $display("FAIL ff_done_hold got done=%0b en=%b expected 1/000", done, {mem_wr_en, mem_rd_en0, mem_rd_en1}); end
  endtask

  task automatic test_stuck_at();
    int cyc, gaps;
    fault_mode = 1;
    kick();
    wait_done(0, 0, cyc, gaps);
    checks++; if (cyc !== 161) begin errors++; $display("FAIL sa_done_cycle got %0d expected 161", cyc); end
    checks++; if (fail !== 1'b1 || fail_addr !== 4'd5 || fail_element !== 3'd1) begin
      errors++; $display("FAIL sa_location got %0b/%0d/%0d expected 1/5/1", fail, fail_addr, fail_element); end
`ifdef MBIST_DIAG_EN
    checks++; if (fail_data !== 8'h08 || fail_port !== 1'b0 || error_count !== 8'd3) begin
      errors++; $display("FAIL sa_diag got %h/%0b/%0d expected 08/0/3", fail_data, fail_port, error_count); end
`endif
  endtask

  task automatic test_coupling();
    int cyc, gaps;
    fault_mode = 2;
    kick();
    wait_done(0, 0, cyc, gaps);
    checks++; if (cyc !== 161) begin errors++; $display("FAIL cf_done_cycle got %0d expected 161", cyc); end
    checks++; if (fail !== 1'b1 || fail_addr !== 4'd8 || fail_element !== 3'd3) begin
      errors++; $display("FAIL cf_location got %0b/%0d/%0d expected 1/8/3", fail, fail_addr, fail_element); end
`ifdef MBIST_DIAG_EN
    checks++; if (fail_data !== 8'h01 || fail_port !== 1'b0) begin
      errors++; $display("FAIL cf_diag got %h/%0b expected 01/0", fail_data, fail_port); end
`endif
  endtask

  task automatic test_port1();
    int cyc, gaps;
    fault_mode = 3;
    kick();
    wait_done(0, 0, cyc, gaps);
    checks++; if (fail !== 1'b1 || fail_addr !== 4'd15 || fail_element !== 3'd5) begin
      errors++; $display("FAIL p1_location got %0b/%0d/%0d expected 1/15/5", fail, fail_addr, fail_element); end
`ifdef MBIST_DIAG_EN
    checks++; if (fail_port !== 1'b1 || fail_data !== 8'h01 || error_count !== 8'd1) begin
      errors++; $display("FAIL p1_diag got %0b/%h/%0d expected 1/01/1", fail_port, fail_data, error_count); end
`endif
  endtask

  task automatic test_reset_abort();
    int cyc, gaps;
    fault_mode = 1;
    kick();
    repeat (50) @(posedge clock);
    #2;
    checks++; if (fail !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL ab_pre got fail=%0b busy=%0b expected 1/1", fail, busy); end
    reset = 1'b0;
    #1;
    checks++; if ({busy, done, fail, mem_wr_en, mem_rd_en0, mem_rd_en1} !== 6'b0 ||
                  fail_addr !== 4'd0 || fail_element !== 3'd0) begin
      errors++; $display("FAIL ab_cleared got %b/%0d/%0d expected 000000/0/0",
                         {busy, done, fail, mem_wr_en, mem_rd_en0, mem_rd_en1}, fail_addr, fail_element); end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    fault_mode = 0;
    kick();
    wait_done(0, 0, cyc, gaps);
    checks++; if (cyc !== 161 || fail !== 1'b0) begin
      errors++; $display("FAIL ab_rerun got cyc=%0d fail=%0b expected 161/0", cyc, fail); end
  endtask

  task automatic test_back_to_back();
    int base, cyc, gaps;
    fault_mode = 1;
    base = wlog_data.size();
    kick();
    wait_done(20, 100, cyc, gaps);
    checks++; if (cyc !== 161 || gaps !== 0) begin
      errors++; $display("FAIL bb_ignored_start got cyc=%0d gaps=%0d expected 161/0", cyc, gaps); end
    checks++; if (fail !== 1'b1 || fail_addr !== 4'd5) begin
      errors++; $display("FAIL bb_fail_kept got %0b/%0d expected 1/5", fail, fail_addr); end
    checks++; if (seq_errors(base) !== 0) begin
      errors++; $display("FAIL bb_write_seq1 got %0d bad writes expected 0", seq_errors(base)); end
    fault_mode = 0;
    base = wlog_data.size();
    kick();
    checks++; if (done !== 1'b0 || fail !== 1'b0 || fail_addr !== 4'd0 || fail_element !== 3'd0) begin
      errors++; $display("FAIL bb_restart_clear got %0b/%0b/%0d/%0d expected 0/0/0/0", done, fail, fail_addr, fail_element); end
    wait_done(0, 0, cyc, gaps);
    checks++; if (cyc !== 161 || fail !== 1'b0) begin
      errors++; $display("FAIL bb_rerun got cyc=%0d fail=%0b expected 161/0", cyc, fail); end
    checks++; if (seq_errors(base) !== 0) begin
      errors++; $display("FAIL bb_write_seq2 got %0d bad writes expected 0", seq_errors(base)); end
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_stuck_at();
    test_coupling();
    test_port1();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
